calc_ctrl: RTL and testbench

Sequencing controller for the calculator datapath. It collects operand A, the operation (one-hot button select) and operand B from the switches and buttons. It then drives the ALU with an opcode and operands, issues a one-cycle start, waits for done, and holds the result for display. It sits between the debounced board inputs and the ALU/opcode decode.

---
 rtl/calc_ctrl_pkg.sv | 35 +++
 rtl/calc_ctrl_btn_edge.sv | 21 ++
 rtl/calc_ctrl.sv | 155 +++++++++++++++
 tb/tb_calc_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/calc_ctrl_pkg.sv
// Shared calculator definitions: opcodes, controller state codes and button-to-op mapping.
// Used by this controller and by the ALU opcode decode.
package calc_ctrl_pkg;

    localparam logic [2:0] OP_IDLE = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;

    localparam int BTN_ADD = 0;
    localparam int BTN_SUB = 1;
    localparam int BTN_MUL = 2;
    localparam int BTN_XOR = 3;

    typedef enum logic [2:0] {
        ST_LOAD_A = 3'd0,
        ST_SEL_OP = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SHOW   = 3'd4
    } state_t;

    // Caller guarantees a one-hot input; an all-zero vector maps to IDLE.
    function automatic logic [2:0] btn_to_op(input logic [3:0] ev);
        logic [2:0] op;
        op = OP_IDLE;
        if (ev[BTN_ADD]) op = OP_ADD;
        if (ev[BTN_SUB]) op = OP_SUB;
        if (ev[BTN_MUL]) op = OP_MUL;
        if (ev[BTN_XOR]) op = OP_XOR;
        return op;
    endfunction

endpackage

// File: rtl/calc_ctrl_btn_edge.sv
// Rising-edge detector: registers the previous level and flags in & ~prev.
// Zero latency on the event output; no backpressure.
module btn_edge #(
    parameter int N = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_in,
    output logic [N-1:0] o_rise
);

    logic [N-1:0] r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_prev <= '0;
        else          r_prev <= i_in;
    end

    assign o_rise = i_in & ~r_prev;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencer: collects A, op, B from board inputs, starts the ALU and holds its result.
// Start pulse one cycle after the B enter; result registered the cycle alu_done is seen in EXEC.
// No backpressure: EXEC waits for alu_done (bounded by TIMEOUT when CALC_TIMEOUT_EN is defined).
module calc_ctrl
    import calc_ctrl_pkg::*;
#(
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [W-1:0]   i_sw,
    input  logic           i_enter,
    input  logic           i_clr,
    input  logic [3:0]     i_btn,
    input  logic           i_alu_done,
    input  logic [2*W-1:0] i_alu_result,
    output logic [2:0]     o_alu_op,
    output logic [W-1:0]   o_alu_a,
    output logic [W-1:0]   o_alu_b,
    output logic           o_alu_start,
    output logic [2*W-1:0] o_result,
    output logic           o_result_valid,
    output logic           o_busy,
    output logic           o_err,
    output logic [2:0]     o_state
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("calc_ctrl: TIMEOUT must be at least 1");
    end

    logic           w_enter_ev, w_clr_ev;
    logic [3:0]     w_btn_ev;

    btn_edge #(.N(1)) u_enter_edge (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_in(i_enter), .o_rise(w_enter_ev));
    btn_edge #(.N(1)) u_clr_edge   (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_in(i_clr),   .o_rise(w_clr_ev));
    btn_edge #(.N(4)) u_btn_edge   (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_in(i_btn),   .o_rise(w_btn_ev));

    state_t         r_state, w_state_nxt;
    logic [2:0]     r_alu_op, w_alu_op_nxt;
    logic [W-1:0]   r_alu_a, w_alu_a_nxt;
    logic [W-1:0]   r_alu_b, w_alu_b_nxt;
    logic           r_alu_start, w_alu_start_nxt;
    logic [2*W-1:0] r_result, w_result_nxt;
    logic           r_err, w_err_nxt;

`ifdef CALC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]  r_cnt, w_cnt_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else          r_cnt <= w_cnt_nxt;
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_LOAD_A;
            r_alu_op    <= OP_IDLE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_start <= 1'b0;
            r_result    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_alu_op    <= w_alu_op_nxt;
            r_alu_a     <= w_alu_a_nxt;
            r_alu_b     <= w_alu_b_nxt;
            r_alu_start <= w_alu_start_nxt;
            r_result    <= w_result_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_alu_op_nxt    = r_alu_op;
        w_alu_a_nxt     = r_alu_a;
        w_alu_b_nxt     = r_alu_b;
        w_alu_start_nxt = 1'b0;
        w_result_nxt    = r_result;
        w_err_nxt       = r_err;
`ifdef CALC_TIMEOUT_EN
        w_cnt_nxt       = r_cnt;
`endif
        // clr outranks every other event, including alu_done in EXEC.
        if (w_clr_ev) begin
            w_state_nxt  = ST_LOAD_A;
            w_alu_op_nxt = OP_IDLE;
            w_err_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_LOAD_A: begin
                    if (w_enter_ev) begin
                        w_alu_a_nxt  = i_sw;
                        w_alu_op_nxt = OP_IDLE;
                        w_state_nxt  = ST_SEL_OP;
                    end
                end
                ST_SEL_OP: begin
                    if ($onehot(w_btn_ev)) begin
                        w_alu_op_nxt = btn_to_op(w_btn_ev);
                        w_err_nxt    = 1'b0;
                        w_state_nxt  = ST_LOAD_B;
                    end else if ($countones(w_btn_ev) > 1) begin
                        w_err_nxt    = 1'b1;
                    end
                end
                ST_LOAD_B: begin
                    if (w_enter_ev) begin
                        w_alu_b_nxt     = i_sw;
                        w_alu_start_nxt = 1'b1;
                        w_state_nxt     = ST_EXEC;
`ifdef CALC_TIMEOUT_EN
                        w_cnt_nxt       = '0;
`endif
                    end
                end
                ST_EXEC: begin
                    if (i_alu_done) begin
                        w_result_nxt = i_alu_result;
                        w_state_nxt  = ST_SHOW;
`ifdef CALC_TIMEOUT_EN
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        w_err_nxt    = 1'b1;
                        w_result_nxt = '0;
                        w_state_nxt  = ST_LOAD_A;
`endif
                    end
`ifdef CALC_TIMEOUT_EN
                    w_cnt_nxt = r_cnt + CW'(1);
`endif
                end
                ST_SHOW: begin
                    if (w_enter_ev) w_state_nxt = ST_LOAD_A;
                end
                default: w_state_nxt = ST_LOAD_A;
            endcase
        end
    end

    assign o_alu_op       = r_alu_op;
    assign o_alu_a        = r_alu_a;
    assign o_alu_b        = r_alu_b;
    assign o_alu_start    = r_alu_start;
    assign o_result       = r_result;
    assign o_result_valid = (r_state == ST_SHOW);
    assign o_busy         = (r_state == ST_EXEC);
    assign o_err          = r_err;
    assign o_state        = r_state;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl; the timeout scenario runs only when CALC_TIMEOUT_EN is defined.
module tb_calc_ctrl;

    localparam int W = 8;

    logic           clk, rst_n;
    logic [W-1:0]   sw;
    logic           enter, clr;
    logic [3:0]     btn;
    logic           alu_done;
    logic [2*W-1:0] alu_result;
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_a, alu_b;
    logic           alu_start;
    logic [2*W-1:0] result;
    logic           result_valid, busy, err;
    logic [2:0]     state;

    int n_pass = 0;
    int n_total = 0;

    calc_ctrl #(.W(W), .TIMEOUT(10)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sw(sw), .i_enter(enter), .i_clr(clr),
        .i_btn(btn), .i_alu_done(alu_done), .i_alu_result(alu_result),
        .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_start(alu_start),
        .o_result(result), .o_result_valid(result_valid), .o_busy(busy),
        .o_err(err), .o_state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: from LOAD_A, load A, pick op, load B; returns in the first EXEC cycle.
    task automatic to_exec(input logic [W-1:0] a, input logic [3:0] b_btn, input logic [W-1:0] b);
        sw = a; enter = 1'b1; tick();
        enter = 1'b0; btn = b_btn; tick();
        btn = 4'b0; sw = b; enter = 1'b1; tick();
        enter = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d required 0", state); else n_pass++;
        n_total++; if (alu_op !== 3'd0) $display("FAIL reset_op: got %0d required 0", alu_op); else n_pass++;
        n_total++; if ({alu_start, result_valid, busy, err} !== 4'b0) $display("FAIL reset_flags: got %b required 0000", {alu_start, result_valid, busy, err}); else n_pass++;
        n_total++; if ({alu_a, alu_b, result} !== 32'd0) $display("FAIL reset_data: got %h required 0", {alu_a, alu_b, result}); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        sw = 8'd5; enter = 1'b1; tick();
        n_total++; if (state !== 3'd1) $display("FAIL add_state_sel: got %0d required 1", state); else n_pass++;
        n_total++; if (alu_a !== 8'd5) $display("FAIL add_a: got %0d required 5", alu_a); else n_pass++;
        enter = 1'b0; btn = 4'b0001; tick();
        n_total++; if (state !== 3'd2) $display("FAIL add_state_loadb: got %0d required 2", state); else n_pass++;
        n_total++; if (alu_op !== 3'd1) $display("FAIL add_op: got %0d required 1", alu_op); else n_pass++;
        btn = 4'b0; sw = 8'd3; enter = 1'b1; tick();
        enter = 1'b0;
        n_total++; if (alu_start !== 1'b1) $display("FAIL add_start_first: got %b required 1", alu_start); else n_pass++;
        n_total++; if (alu_b !== 8'd3) $display("FAIL add_b: got %0d required 3", alu_b); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL add_busy: got %b required 1", busy); else n_pass++;
        tick();
        n_total++; if (alu_start !== 1'b0) $display("FAIL add_start_second: got %b required 0", alu_start); else n_pass++;
        alu_done = 1'b1; alu_result = 16'd8; tick();
        alu_done = 1'b0;
        n_total++; if (state !== 3'd4) $display("FAIL add_state_show: got %0d required 4", state); else n_pass++;
        n_total++; if (result !== 16'd8) $display("FAIL add_result: got %0d required 8", result); else n_pass++;
        n_total++; if (result_valid !== 1'b1) $display("FAIL add_valid: got %b required 1", result_valid); else n_pass++;
        enter = 1'b1; tick();
        enter = 1'b0;
        n_total++; if (state !== 3'd0) $display("FAIL add_back_loada: got %0d required 0", state); else n_pass++;
        n_total++; if (result !== 16'd8 || result_valid !== 1'b0) $display("FAIL add_hold: got result %0d valid %b required 8 valid 0", result, result_valid); else n_pass++;
        tick();
    endtask

    task automatic test_mul_latency();
        int busy_cycles;
        busy_cycles = 0;
        to_exec(8'd200, 4'b0100, 8'd200);
        for (int i = 0; i < 4; i++) begin
            if (busy === 1'b1) busy_cycles++;
            n_total++; if (alu_op !== 3'd3 || alu_a !== 8'd200 || alu_b !== 8'd200) $display("FAIL mul_stable_%0d: got op %0d a %0d b %0d required 3 200 200", i, alu_op, alu_a, alu_b); else n_pass++;
            if (i == 3) begin
                alu_done = 1'b1; alu_result = 16'd40000;
            end
            tick();
        end
        alu_done = 1'b0;
        n_total++; if (busy_cycles !== 4) $display("FAIL mul_busy_cycles: got %0d required 4", busy_cycles); else n_pass++;
        n_total++; if (result !== 16'd40000 || result_valid !== 1'b1 || busy !== 1'b0) $display("FAIL mul_result: got %0d valid %b busy %b required 40000 1 0", result, result_valid, busy); else n_pass++;
        enter = 1'b1; tick();
        enter = 1'b0; tick();
    endtask

    task automatic test_multi_hot();
        sw = 8'd1; enter = 1'b1; tick();
        enter = 1'b0; btn = 4'b0101; tick();
        n_total++; if (err !== 1'b1 || state !== 3'd1) $display("FAIL multi_err: got err %b state %0d required 1 1", err, state); else n_pass++;
        btn = 4'b0; tick();
        btn = 4'b0100; tick();
        btn = 4'b0;
        n_total++; if (err !== 1'b0 || alu_op !== 3'd3 || state !== 3'd2) $display("FAIL multi_recover: got err %b op %0d state %0d required 0 3 2", err, alu_op, state); else n_pass++;
    endtask

    task automatic test_abort();
        sw = 8'd2; enter = 1'b1; tick();
        enter = 1'b0;
        n_total++; if (state !== 3'd3) $display("FAIL abort_exec: got %0d required 3", state); else n_pass++;
        tick();
        clr = 1'b1; tick();
        clr = 1'b0;
        n_total++; if (state !== 3'd0 || alu_op !== 3'd0 || busy !== 1'b0 || alu_start !== 1'b0) $display("FAIL abort_clear: got state %0d op %0d busy %b start %b required 0 0 0 0", state, alu_op, busy, alu_start); else n_pass++;
        alu_done = 1'b1; alu_result = 16'd1234; tick();
        alu_done = 1'b0;
        n_total++; if (result !== 16'd40000 || state !== 3'd0) $display("FAIL abort_late_done: got result %0d state %0d required 40000 0", result, state); else n_pass++;
    endtask

    task automatic test_async_reset();
        to_exec(8'd7, 4'b0001, 8'd9);
        n_total++; if (busy !== 1'b1) $display("FAIL areset_pre: got busy %b required 1", busy); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (state !== 3'd0 || alu_op !== 3'd0 || busy !== 1'b0 || alu_start !== 1'b0) $display("FAIL areset_ctrl: got state %0d op %0d busy %b start %b required 0 0 0 0", state, alu_op, busy, alu_start); else n_pass++;
        n_total++; if ({alu_a, alu_b, result, err, result_valid} !== 34'd0) $display("FAIL areset_data: got %h required 0", {alu_a, alu_b, result, err, result_valid}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_total++; if (state !== 3'd0) $display("FAIL areset_release: got %0d required 0", state); else n_pass++;
    endtask

`ifdef CALC_TIMEOUT_EN
    task automatic test_timeout();
        to_exec(8'd4, 4'b1000, 8'd6);
        for (int i = 0; i < 9; i++) tick();
        n_total++; if (state !== 3'd3) $display("FAIL to_done_pending: got %0d required 3", state); else n_pass++;
        alu_done = 1'b1; alu_result = 16'd77; tick();
        alu_done = 1'b0;
        n_total++; if (state !== 3'd4 || result !== 16'd77 || err !== 1'b0) $display("FAIL to_done_wins: got state %0d result %0d err %b required 4 77 0", state, result, err); else n_pass++;
        enter = 1'b1; tick();
        enter = 1'b0; tick();
        to_exec(8'd4, 4'b1000, 8'd6);
        for (int i = 0; i < 9; i++) tick();
        n_total++; if (state !== 3'd3) $display("FAIL to_still_exec: got %0d required 3", state); else n_pass++;
        tick();
        n_total++; if (state !== 3'd0 || err !== 1'b1 || result !== 16'd0 || result_valid !== 1'b0) $display("FAIL to_expire: got state %0d err %b result %0d valid %b required 0 1 0 0", state, err, result, result_valid); else n_pass++;
    endtask
`endif

    initial begin
        rst_n = 1'b0; sw = '0; enter = 1'b0; clr = 1'b0; btn = 4'b0;
        alu_done = 1'b0; alu_result = '0;
        test_reset();
        test_add();
        test_mul_latency();
        test_multi_hot();
        test_abort();
        test_async_reset();
`ifdef CALC_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
